// File: rtl/hv_resp_parser_pkg.sv
// Shared protocol constants and state encoding for the HV supply serial frame
// (STX, payload, ETX, two ASCII-hex checksum chars, CR).
package hv_resp_parser_pkg;

  localparam logic [7:0] HV_STX = 8'h02;
  localparam logic [7:0] HV_ETX = 8'h03;
  localparam logic [7:0] HV_CR  = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CHK_HI,
    ST_CHK_LO,
    ST_WAIT_CR
  } state_t;

endpackage

// File: rtl/hv_ascii_hex_decode.sv
// Combinational uppercase ASCII-hex character to nibble decoder.
// Lowercase letters and every other code are reported as invalid.
module hv_ascii_hex_decode (
  input  logic [7:0] code,
  output logic       valid,
  output logic [3:0] nibble
);

  always_comb begin
    valid  = 1'b0;
    nibble = 4'h0;
    if (code >= 8'h30 && code <= 8'h39) begin
      valid  = 1'b1;
      nibble = code[3:0];
    end else if (code >= 8'h41 && code <= 8'h46) begin
      valid  = 1'b1;
      nibble = code[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/hv_resp_parser.sv
// Receive-side HV supply frame decoder: validates framing and checksum of
// STX/payload/ETX/hex-checksum/CR frames and publishes the payload of good frames.
module hv_resp_parser
  import hv_resp_parser_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 16,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic                             Clk_In,
  input  logic                             Rst,
  input  logic [7:0]                       In_Byte,
  input  logic                             In_Byte_En,
  output logic [8*MAX_PAYLOAD-1:0]         Out_Payload,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] Out_Payload_Len,
  output logic                             Out_Valid,
  output logic                             Out_Err_Checksum,
  output logic                             Out_Err_Frame,
  output logic [7:0]                       Out_Err_Cnt
);

  localparam int CW = $clog2(MAX_PAYLOAD + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = 8 * MAX_PAYLOAD;

  state_t          state, state_n;
  logic [7:0]      sum, sum_n;
  logic [CW-1:0]   count, count_n;
  logic [TW-1:0]   timer, timer_n;
  logic [3:0]      chk_hi, chk_hi_n;
  logic [7:0]      chk_rx, chk_rx_n;
  logic [PW-1:0]   payload_buf, payload_buf_n;
  logic            valid_n, err_chk_n, err_frame_n;
  logic            hex_valid;
  logic [3:0]      hex_nibble;

  hv_ascii_hex_decode u_hex (
    .code   (In_Byte),
    .valid  (hex_valid),
    .nibble (hex_nibble)
  );

  always_comb begin
    state_n       = state;
    sum_n         = sum;
    count_n       = count;
    timer_n       = timer;
    chk_hi_n      = chk_hi;
    chk_rx_n      = chk_rx;
    payload_buf_n = payload_buf;
    valid_n       = 1'b0;
    err_chk_n     = 1'b0;
    err_frame_n   = 1'b0;

    if (In_Byte_En) begin
      // A strobe always restarts the inter-byte timer, even on the expiry cycle.
      timer_n = '0;
      case (state)
        ST_IDLE: begin
          if (In_Byte == HV_STX) begin
            state_n       = ST_PAYLOAD;
            sum_n         = HV_STX;
            count_n       = '0;
            payload_buf_n = '0;
          end
        end
        ST_PAYLOAD: begin
          if (In_Byte == HV_ETX) begin
            state_n = ST_CHK_HI;
            sum_n   = sum + HV_ETX;
          end else if (In_Byte == HV_STX) begin
            err_frame_n   = 1'b1;
            sum_n         = HV_STX;
            count_n       = '0;
            payload_buf_n = '0;
          end else if (count == CW'(MAX_PAYLOAD)) begin
            err_frame_n = 1'b1;
            state_n     = ST_IDLE;
          end else begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
              if (count == CW'(i)) payload_buf_n[PW-8-8*i +: 8] = In_Byte;
            end
            sum_n   = sum + In_Byte;
            count_n = count + 1'b1;
          end
        end
        ST_CHK_HI: begin
          if (hex_valid) begin
            chk_hi_n = hex_nibble;
            state_n  = ST_CHK_LO;
          end else begin
            err_frame_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end
        ST_CHK_LO: begin
          if (hex_valid) begin
            chk_rx_n = {chk_hi, hex_nibble};
            state_n  = ST_WAIT_CR;
          end else begin
            err_frame_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end
        ST_WAIT_CR: begin
          state_n = ST_IDLE;
          if (In_Byte != HV_CR) err_frame_n = 1'b1;
          else if (chk_rx == sum) valid_n = 1'b1;
          else err_chk_n = 1'b1;
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        err_frame_n = 1'b1;
        state_n     = ST_IDLE;
        timer_n     = '0;
      end else begin
        timer_n = timer + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Rst) begin
      state            <= ST_IDLE;
      sum              <= '0;
      count            <= '0;
      timer            <= '0;
      Out_Payload      <= '0;
      Out_Payload_Len  <= '0;
      Out_Valid        <= 1'b0;
      Out_Err_Checksum <= 1'b0;
      Out_Err_Frame    <= 1'b0;
      Out_Err_Cnt      <= '0;
    end else begin
      state            <= state_n;
      sum              <= sum_n;
      count            <= count_n;
      timer            <= timer_n;
      Out_Valid        <= valid_n;
      Out_Err_Checksum <= err_chk_n;
      Out_Err_Frame    <= err_frame_n;
      if (valid_n) begin
        Out_Payload     <= payload_buf;
        Out_Payload_Len <= count;
      end
      if ((err_chk_n || err_frame_n) && Out_Err_Cnt != 8'hFF)
        Out_Err_Cnt <= Out_Err_Cnt + 1'b1;
    end
  end

  // Frame working storage; cleared on every STX, so no reset is needed.
  always_ff @(posedge Clk_In) begin
    chk_hi      <= chk_hi_n;
    chk_rx      <= chk_rx_n;
    payload_buf <= payload_buf_n;
  end

endmodule
